usb_line_xcvr: RTL and testbench
================================

Name: usb_line_xcvr

Overview:
- Parametrised next-generation DP/DM line transceiver for the USB host.
- Serialises encoder bitstreams onto dp_w/dm_w with configurable packet lengths and EOP shape; tx start/done handshake plus bus output-enable.
- Receives device bitstreams on dp_r/dm_r and checks EOP framing. Reports rx timeout, line errors and received bit count to the protocol FSM and the unencoding pipeline.

Parameters:
- TOK_BITS, 32, token packet line bits (sync + info)
- DATA_BITS, 92, data packet line bits
- HS_BITS, 12, handshake packet line bits
- EOP_SE0, 2, SE0 cycles driven at EOP; also the nominal rx SE0 length
- EOP_J, 1, J cycles driven after SE0 before release
- RX_TIMEOUT, 255, max cycles armed receiver waits for first K
- CW, 8, width of bit/timeout counters; must hold max(DATA_BITS, RX_TIMEOUT, EOP_SE0+1)

Ports:
- clk  in  1  clock
- rst_b  in  1  async active-low reset
- tx_start  in  1  start request; accepted only when tx_busy=0 and tx_type!=0
- tx_type  in  2  01 token, 10 data, 11 handshake, 00 ignored
- tx_bit  in  1  next line bit from encoder, sampled when tx_bit_req=1
- tx_bit_req  out  1  encoder must present a valid bit this cycle
- tx_busy  out  1  transmitter not idle
- tx_done  out  1  one-cycle pulse, last EOP J cycle
- dp_w, dm_w  out  1  driven line pair
- tx_oe  out  1  host drives bus
- rx_arm  in  1  pulse: start listening for device packet
- dp_r, dm_r  in  1  received line pair (already synchronised)
- rx_bit  out  1  received bit (= dp_r)
- rx_valid  out  1  rx_bit valid this cycle
- rx_done  out  1  pulse: well-formed EOP seen
- rx_err  out  1  pulse: SE1 or malformed EOP
- rx_timeout  out  1  pulse: no K within RX_TIMEOUT
- rx_count  out  CW  bits received in current/last packet

Behaviour:
- Reset: both FSMs idle; dp_w=1, dm_w=0 (J); tx_oe, tx_bit_req, tx_busy, tx_done, rx_valid, rx_done, rx_err, rx_timeout = 0; rx_count=0.
- Line outputs dp_w/dm_w/tx_oe are registered. A mid-operation reset returns immediately to J and idle; no EOP is emitted.
- TX FSM states: T_IDLE, T_DATA, T_SE0, T_J.
- T_IDLE -> T_DATA on accepted tx_start. LEN is latched from tx_type; tx_type is ignored after acceptance.
- T_DATA: tx_bit_req=1 combinationally for exactly LEN cycles, starting the cycle after acceptance. Each edge registers dp_w=tx_bit, dm_w=~tx_bit. Line data lags tx_bit_req by 1 cycle.
- T_SE0: EOP_SE0 cycles of dp_w=dm_w=0.
- T_J: EOP_J cycles of J; tx_done high on the final one; then T_IDLE.
- tx_oe=1 from the first data line cycle through the last EOP J cycle.
- tx_busy=1 in every non-idle state. tx_start while busy is dropped, not queued.
- RX FSM states: R_IDLE, R_WAIT, R_DATA, R_EOP.
- R_IDLE: rx_arm -> R_WAIT, rx_count cleared, wait counter cleared. rx_arm while tx_busy=1 is ignored. rx_arm in any other state restarts R_WAIT.
- R_WAIT: K (dp=0, dm=1) -> R_DATA. This K cycle is the first valid bit.
- R_WAIT timeout: wait counter reaching RX_TIMEOUT cycles without K -> rx_timeout pulse, R_IDLE.
- R_DATA: rx_valid=1 and rx_count++ (saturating) on each J/K cycle.
- R_DATA, SE0 -> R_EOP with SE0 counter=1. SE1 (dp=dm=1) -> rx_err, R_IDLE.
- R_EOP: SE0 increments the counter; more than EOP_SE0+1 consecutive SE0 -> rx_err, R_IDLE.
- R_EOP: J -> rx_done, R_IDLE. K or SE1 -> rx_err, R_IDLE. rx_valid=0 throughout.
- rx_count holds its value in R_IDLE until the next rx_arm.
- Only one of rx_done/rx_err/rx_timeout may pulse per armed packet.
- TX and RX are independent apart from the rx_arm-while-busy rule.

Test Plan:
- Token: tx_start, type=01, bits alternating 1,0 -> tx_bit_req high 32 cycles; 32 line cycles K/J; 2 SE0 cycles; 1 J with tx_done; tx_oe high 35 cycles; then J, tx_busy=0.
- Data back-to-back: type=10; second tx_start during T_DATA -> ignored. 92 data cycles; new start accepted only after tx_done.
- RX good: rx_arm, 3 idle J cycles, then K + 11 J/K, 2 SE0, J -> rx_valid 12 cycles; rx_count=12; rx_done 1 pulse; no rx_err.
- RX timeout: rx_arm, line held J -> rx_timeout exactly 255 cycles later; rx_count=0; FSM idle.
- RX errors: SE1 mid-packet -> rx_err. Separately, 4 SE0 cycles (EOP_SE0=2) -> rx_err on the 4th. Separately, SE0 then K -> rx_err.
- Reset mid-TX: assert rst_b low in T_SE0 -> dp_w=1, dm_w=0, tx_oe=0, tx_busy=0 immediately; no tx_done.

Source files
------------

// File: rtl/usb_line_xcvr_if.sv
// Protocol-side and line-side signal bundle of the USB host line transceiver.
// The slave modport is the transceiver; the master modport is the host FSM/encoder and bus model.
interface usb_line_xcvr_if #(
    parameter int unsigned CW = 8
);

    logic          tx_start;
    logic [1:0]    tx_type;
    logic          tx_bit;
    logic          tx_bit_req;
    logic          tx_busy;
    logic          tx_done;
    logic          dp_w;
    logic          dm_w;
    logic          tx_oe;
    logic          rx_arm;
    logic          dp_r;
    logic          dm_r;
    logic          rx_bit;
    logic          rx_valid;
    logic          rx_done;
    logic          rx_err;
    logic          rx_timeout;
    logic [CW-1:0] rx_count;

    modport master (
        output tx_start, tx_type, tx_bit, rx_arm, dp_r, dm_r,
        input  tx_bit_req, tx_busy, tx_done, dp_w, dm_w, tx_oe,
        input  rx_bit, rx_valid, rx_done, rx_err, rx_timeout, rx_count
    );

    modport slave (
        input  tx_start, tx_type, tx_bit, rx_arm, dp_r, dm_r,
        output tx_bit_req, tx_busy, tx_done, dp_w, dm_w, tx_oe,
        output rx_bit, rx_valid, rx_done, rx_err, rx_timeout, rx_count
    );

endinterface

// File: rtl/usb_line_xcvr.sv
// Host-side USB DP/DM line transceiver: serialises encoder bits and appends an EOP on transmit,
// and frames and validates device packets on receive.
module usb_line_xcvr #(
    parameter int unsigned TOK_BITS   = 32,
    parameter int unsigned DATA_BITS  = 92,
    parameter int unsigned HS_BITS    = 12,
    parameter int unsigned EOP_SE0    = 2,
    parameter int unsigned EOP_J      = 1,
    parameter int unsigned RX_TIMEOUT = 255,
    parameter int unsigned CW         = 8
) (
    input logic            clk,
    input logic            rst_b,
    usb_line_xcvr_if.slave bus
);

    typedef enum logic [1:0] {T_IDLE, T_DATA, T_SE0, T_J} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA, R_EOP} rx_state_t;

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] SE0_LAST = CW'(EOP_SE0 - 1);
    localparam logic [CW-1:0] J_LAST   = CW'(EOP_J - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(RX_TIMEOUT - 1);
    localparam logic [CW-1:0] SE0_MAX  = CW'(EOP_SE0 + 1);

    // ---------------------------------------------------------------- transmit
    tx_state_t     tx_state;
    logic [CW-1:0] tx_len;
    logic [CW-1:0] tx_cnt;
    logic [CW-1:0] start_len;
    logic          dp_q;
    logic          dm_q;
    logic          oe_q;
    logic          done_q;
    logic          tx_busy;
    logic          tx_accept;

    always_comb begin
        start_len = '0;
        unique case (bus.tx_type)
            2'b01:   start_len = CW'(TOK_BITS);
            2'b10:   start_len = CW'(DATA_BITS);
            2'b11:   start_len = CW'(HS_BITS);
            default: start_len = '0;
        endcase
    end

    // The line lags the FSM by one register, so busy also covers the final J cycle still on the bus.
    assign tx_busy   = (tx_state != T_IDLE) || oe_q;
    assign tx_accept = bus.tx_start && (bus.tx_type != 2'b00) && !tx_busy;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            tx_state <= T_IDLE;
            tx_len   <= '0;
            tx_cnt   <= '0;
            dp_q     <= 1'b1;
            dm_q     <= 1'b0;
            oe_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (tx_state)
                T_IDLE: begin
                    dp_q <= 1'b1;
                    dm_q <= 1'b0;
                    oe_q <= 1'b0;
                    if (tx_accept) begin
                        tx_state <= T_DATA;
                        tx_len   <= start_len;
                        tx_cnt   <= '0;
                    end
                end
                T_DATA: begin
                    dp_q <= bus.tx_bit;
                    dm_q <= ~bus.tx_bit;
                    oe_q <= 1'b1;
                    if (tx_cnt == tx_len - ONE) begin
                        tx_state <= T_SE0;
                        tx_cnt   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt + ONE;
                    end
                end
                T_SE0: begin
                    dp_q <= 1'b0;
                    dm_q <= 1'b0;
                    oe_q <= 1'b1;
                    if (tx_cnt == SE0_LAST) begin
                        tx_state <= T_J;
                        tx_cnt   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt + ONE;
                    end
                end
                T_J: begin
                    dp_q <= 1'b1;
                    dm_q <= 1'b0;
                    oe_q <= 1'b1;
                    if (tx_cnt == J_LAST) begin
                        done_q   <= 1'b1;
                        tx_state <= T_IDLE;
                        tx_cnt   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt + ONE;
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end

    assign bus.tx_bit_req = (tx_state == T_DATA);
    assign bus.tx_busy    = tx_busy;
    assign bus.tx_done    = done_q;
    assign bus.dp_w       = dp_q;
    assign bus.dm_w       = dm_q;
    assign bus.tx_oe      = oe_q;

    // ----------------------------------------------------------------- receive
    rx_state_t     rx_state;
    logic [CW-1:0] rx_count;
    logic [CW-1:0] rx_tmr;
    logic [CW-1:0] count_inc;
    logic          ln_j;
    logic          ln_k;
    logic          ln_se0;
    logic          ln_se1;
    logic          arm_ok;
    logic          rx_valid;
    logic          rx_done;
    logic          rx_err;
    logic          rx_timeout;

    assign ln_j      = bus.dp_r & ~bus.dm_r;
    assign ln_k      = ~bus.dp_r & bus.dm_r;
    assign ln_se0    = ~bus.dp_r & ~bus.dm_r;
    assign ln_se1    = bus.dp_r & bus.dm_r;
    assign arm_ok    = bus.rx_arm && ((rx_state != R_IDLE) || !tx_busy);
    assign count_inc = (&rx_count) ? rx_count : rx_count + ONE;

    // Status is decoded in the same cycle as the line symbol; rx_tmr doubles as wait and SE0 counter.
    always_comb begin
        rx_valid   = 1'b0;
        rx_done    = 1'b0;
        rx_err     = 1'b0;
        rx_timeout = 1'b0;
        if (!arm_ok) begin
            unique case (rx_state)
                R_WAIT: begin
                    rx_valid   = ln_k;
                    rx_timeout = !ln_k && (rx_tmr == TMO_LAST);
                end
                R_DATA: begin
                    rx_valid = ln_j | ln_k;
                    rx_err   = ln_se1;
                end
                R_EOP: begin
                    rx_done = ln_j;
                    rx_err  = ln_k | ln_se1 | (ln_se0 && (rx_tmr == SE0_MAX));
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rx_state <= R_IDLE;
            rx_count <= '0;
            rx_tmr   <= '0;
        end else if (arm_ok) begin
            rx_state <= R_WAIT;
            rx_count <= '0;
            rx_tmr   <= '0;
        end else begin
            unique case (rx_state)
                R_WAIT: begin
                    if (ln_k) begin
                        rx_state <= R_DATA;
                        rx_count <= count_inc;
                    end else if (rx_timeout) begin
                        rx_state <= R_IDLE;
                    end else begin
                        rx_tmr <= rx_tmr + ONE;
                    end
                end
                R_DATA: begin
                    if (rx_valid) begin
                        rx_count <= count_inc;
                    end else if (ln_se0) begin
                        rx_state <= R_EOP;
                        rx_tmr   <= ONE;
                    end else begin
                        rx_state <= R_IDLE;
                    end
                end
                R_EOP: begin
                    if (ln_se0 && !rx_err) begin
                        rx_tmr <= rx_tmr + ONE;
                    end else begin
                        rx_state <= R_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_bit     = bus.dp_r;
    assign bus.rx_valid   = rx_valid;
    assign bus.rx_done    = rx_done;
    assign bus.rx_err     = rx_err;
    assign bus.rx_timeout = rx_timeout;
    assign bus.rx_count   = rx_count;

endmodule

// File: tb/tb_usb_line_xcvr.sv
// Directed bench for usb_line_xcvr: transmit framing, handshake rules, receive framing and errors,
// and asynchronous reset in the middle of an EOP.
module tb_usb_line_xcvr;

    localparam logic [1:0] LJ   = 2'b10;
    localparam logic [1:0] LK   = 2'b01;
    localparam logic [1:0] LSE0 = 2'b00;
    localparam logic [1:0] LSE1 = 2'b11;

    logic clk;
    logic rst_b;
    int   n_cmp;
    int   n_bad;
    logic txb [0:127];
    logic [1:0] pkt [0:11];

    usb_line_xcvr_if #(.CW(8)) bus ();

    usb_line_xcvr #(
        .TOK_BITS  (32),
        .DATA_BITS (92),
        .HS_BITS   (12),
        .EOP_SE0   (2),
        .EOP_J     (1),
        .RX_TIMEOUT(255),
        .CW        (8)
    ) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rx_step(input logic [1:0] sym, input logic arm);
        @(negedge clk);
        bus.rx_arm = arm;
        {bus.dp_r, bus.dm_r} = sym;
        #1;
    endtask

    // Runs one packet; k counts cycles after the accept cycle (k=0).
    task automatic tx_packet(input string nm, input logic [1:0] typ, input int len, input int inject);
        int   req_n;
        int   oe_n;
        int   done_n;
        logic exp_dp;
        logic exp_dm;
        req_n  = 0;
        oe_n   = 0;
        done_n = 0;
        for (int j = 0; j < len; j++)
            txb[j] = (typ == 2'b01) ? (j % 2 == 0) : ((j % 3 == 0) || (j % 5 == 1));
        @(negedge clk);
        bus.tx_type  = typ;
        bus.tx_start = 1'b1;
        #1;
        chk({nm, " busy_pre"}, bus.tx_busy, 1'b0);
        chk({nm, " req_pre"}, bus.tx_bit_req, 1'b0);
        for (int k = 1; k <= len + 6; k++) begin
            @(negedge clk);
            bus.tx_type  = 2'b11;
            bus.tx_start = (k == inject) || (k == len + 4);
            bus.tx_bit   = (k <= len) ? txb[k-1] : 1'b0;
            bus.rx_arm   = (k == 3);
            {bus.dp_r, bus.dm_r} = (k == 4 || k == 5) ? LK : LJ;
            #1;
            if (k == 1 || k >= len + 4) begin
                exp_dp = 1'b1;
                exp_dm = 1'b0;
            end else if (k <= len + 1) begin
                exp_dp = txb[k-2];
                exp_dm = ~txb[k-2];
            end else begin
                exp_dp = 1'b0;
                exp_dm = 1'b0;
            end
            chk($sformatf("%s req k=%0d", nm, k), bus.tx_bit_req, k <= len);
            chk($sformatf("%s busy k=%0d", nm, k), bus.tx_busy, k <= len + 4);
            chk($sformatf("%s dp k=%0d", nm, k), bus.dp_w, exp_dp);
            chk($sformatf("%s dm k=%0d", nm, k), bus.dm_w, exp_dm);
            chk($sformatf("%s oe k=%0d", nm, k), bus.tx_oe, (k >= 2) && (k <= len + 4));
            chk($sformatf("%s done k=%0d", nm, k), bus.tx_done, k == len + 4);
            if (k == 4 || k == 5)
                chk($sformatf("%s rx_arm_busy k=%0d", nm, k), bus.rx_valid, 1'b0);
            req_n  += int'(bus.tx_bit_req);
            oe_n   += int'(bus.tx_oe);
            done_n += int'(bus.tx_done);
        end
        bus.tx_start = 1'b0;
        bus.rx_arm   = 1'b0;
        chk({nm, " req_total"}, req_n, len);
        chk({nm, " oe_total"}, oe_n, len + 3);
        chk({nm, " done_total"}, done_n, 1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_b = 1'b0;
        bus.tx_start = 1'b0;
        bus.tx_type  = 2'b00;
        bus.tx_bit   = 1'b0;
        bus.rx_arm   = 1'b0;
        bus.dp_r     = 1'b1;
        bus.dm_r     = 1'b0;
        pkt = '{LK, LJ, LK, LK, LJ, LJ, LK, LJ, LK, LK, LK, LJ};
        repeat (3) @(negedge clk);
        #1;
        chk("rst dp", bus.dp_w, 1'b1);
        chk("rst dm", bus.dm_w, 1'b0);
        rst_b = 1'b1;
        @(negedge clk);
        #1;
        chk("rst oe", bus.tx_oe, 1'b0);
        chk("rst req", bus.tx_bit_req, 1'b0);
        chk("rst busy", bus.tx_busy, 1'b0);
        chk("rst tx_done", bus.tx_done, 1'b0);
        chk("rst rx_valid", bus.rx_valid, 1'b0);
        chk("rst rx_done", bus.rx_done, 1'b0);
        chk("rst rx_err", bus.rx_err, 1'b0);
        chk("rst rx_timeout", bus.rx_timeout, 1'b0);
        chk("rst rx_count", bus.rx_count, 8'd0);

        // tx_type 00 must not start anything
        @(negedge clk);
        bus.tx_type  = 2'b00;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        #1;
        chk("type00 busy", bus.tx_busy, 1'b0);
        chk("type00 req", bus.tx_bit_req, 1'b0);

        tx_packet("tok", 2'b01, 32, 0);
        tx_packet("dat", 2'b10, 92, 10);
        tx_packet("hs", 2'b11, 12, 5);

        // Receive: well-formed packet after three idle J cycles
        rx_step(LJ, 1'b1);
        chk("rxg arm_valid", bus.rx_valid, 1'b0);
        for (int c = 0; c < 3; c++) begin
            rx_step(LJ, 1'b0);
            chk($sformatf("rxg idle_valid c=%0d", c), bus.rx_valid, 1'b0);
        end
        for (int i = 0; i < 12; i++) begin
            rx_step(pkt[i], 1'b0);
            chk($sformatf("rxg valid i=%0d", i), bus.rx_valid, 1'b1);
            chk($sformatf("rxg bit i=%0d", i), bus.rx_bit, pkt[i][1]);
            chk($sformatf("rxg count i=%0d", i), bus.rx_count, i);
            chk($sformatf("rxg err i=%0d", i), bus.rx_err, 1'b0);
        end
        for (int c = 0; c < 2; c++) begin
            rx_step(LSE0, 1'b0);
            chk($sformatf("rxg se0_valid c=%0d", c), bus.rx_valid, 1'b0);
            chk($sformatf("rxg se0_done c=%0d", c), bus.rx_done, 1'b0);
            chk($sformatf("rxg se0_err c=%0d", c), bus.rx_err, 1'b0);
        end
        rx_step(LJ, 1'b0);
        chk("rxg done", bus.rx_done, 1'b1);
        chk("rxg done_err", bus.rx_err, 1'b0);
        chk("rxg count", bus.rx_count, 8'd12);
        rx_step(LJ, 1'b0);
        chk("rxg done_once", bus.rx_done, 1'b0);
        chk("rxg count_hold", bus.rx_count, 8'd12);

        // Receive timeout: line held at J
        rx_step(LJ, 1'b1);
        for (int c = 1; c <= 256; c++) begin
            rx_step(LJ, 1'b0);
            chk($sformatf("tmo pulse c=%0d", c), bus.rx_timeout, c == 255);
            if (c == 1 || c == 256) chk($sformatf("tmo count c=%0d", c), bus.rx_count, 8'd0);
        end
        rx_step(LK, 1'b0);
        chk("tmo idle_valid", bus.rx_valid, 1'b0);

        // SE1 in the middle of a packet
        rx_step(LJ, 1'b1);
        rx_step(LK, 1'b0);
        rx_step(LJ, 1'b0);
        rx_step(LK, 1'b0);
        rx_step(LSE1, 1'b0);
        chk("se1 err", bus.rx_err, 1'b1);
        chk("se1 done", bus.rx_done, 1'b0);
        rx_step(LK, 1'b0);
        chk("se1 idle_valid", bus.rx_valid, 1'b0);
        chk("se1 err_once", bus.rx_err, 1'b0);
        chk("se1 count", bus.rx_count, 8'd3);

        // Over-long SE0 at EOP
        rx_step(LJ, 1'b1);
        rx_step(LK, 1'b0);
        rx_step(LJ, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            rx_step(LSE0, 1'b0);
            chk($sformatf("longse0 err c=%0d", c), bus.rx_err, 1'b0);
        end
        rx_step(LSE0, 1'b0);
        chk("longse0 err4", bus.rx_err, 1'b1);
        rx_step(LJ, 1'b0);
        chk("longse0 no_done", bus.rx_done, 1'b0);
        chk("longse0 err_once", bus.rx_err, 1'b0);

        // SE0 followed by K
        rx_step(LJ, 1'b1);
        rx_step(LK, 1'b0);
        rx_step(LSE0, 1'b0);
        rx_step(LK, 1'b0);
        chk("se0k err", bus.rx_err, 1'b1);
        chk("se0k done", bus.rx_done, 1'b0);
        rx_step(LK, 1'b0);
        chk("se0k idle_valid", bus.rx_valid, 1'b0);

        // Re-arm in R_DATA restarts the wait for K
        rx_step(LJ, 1'b1);
        rx_step(LK, 1'b0);
        rx_step(LJ, 1'b0);
        rx_step(LK, 1'b1);
        chk("rearm valid", bus.rx_valid, 1'b0);
        rx_step(LJ, 1'b0);
        chk("rearm wait_valid", bus.rx_valid, 1'b0);
        chk("rearm count", bus.rx_count, 8'd0);
        rx_step(LK, 1'b0);
        chk("rearm first_k", bus.rx_valid, 1'b1);
        rx_step(LJ, 1'b0);
        chk("rearm count1", bus.rx_count, 8'd1);
        bus.rx_arm = 1'b0;

        // Asynchronous reset while the EOP SE0 is on the line
        @(negedge clk);
        bus.tx_type  = 2'b01;
        bus.tx_start = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            bus.tx_start = 1'b0;
            bus.tx_bit   = (k % 2 == 1);
        end
        #1;
        chk("mrst pre_dp", bus.dp_w, 1'b0);
        chk("mrst pre_oe", bus.tx_oe, 1'b1);
        rst_b = 1'b0;
        #1;
        chk("mrst dp", bus.dp_w, 1'b1);
        chk("mrst dm", bus.dm_w, 1'b0);
        chk("mrst oe", bus.tx_oe, 1'b0);
        chk("mrst busy", bus.tx_busy, 1'b0);
        chk("mrst done", bus.tx_done, 1'b0);
        @(negedge clk);
        rst_b = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("mrst after_done c=%0d", c), bus.tx_done, 1'b0);
            chk($sformatf("mrst after_oe c=%0d", c), bus.tx_oe, 1'b0);
            chk($sformatf("mrst after_dp c=%0d", c), bus.dp_w, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
